// File: rtl/full_subtractor_serial8_if.sv
// full_subtractor_serial8_if: start/busy/done handshake and operand/result bus.
// ovf is present only when SERIAL_SUB_OVF_EN is defined.
interface full_subtractor_serial8_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, A, B, Bin,
        input  D, Bout, busy, done
`ifdef SERIAL_SUB_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  start, A, B, Bin,
        output D, Bout, busy, done
`ifdef SERIAL_SUB_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/full_subtractor_serial8.sv
// full_subtractor_serial8: bit-serial A - B - Bin, one cell reused LSB-first.
// Define SERIAL_SUB_OVF_EN to add the signed overflow flag (ovf).
module full_subtractor_serial8 #(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst,
    full_subtractor_serial8_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             load;
    logic             step;
    logic             last;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sr;
    logic             bor;

    logic [WIDTH-1:0] d_q;
    logic             bout_q;

    logic             a_i;
    logic             b_i;
    logic             d_i;
    logic             bor_nx;

    assign last = (cnt == CW'(WIDTH - 1));

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and load/step strobes; start only counts outside SHIFT.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The single full-subtractor cell working on the current LSBs.
    always_comb begin
        a_i    = a_sh[0];
        b_i    = b_sh[0];
        d_i    = a_i ^ b_i ^ bor;
        bor_nx = (~a_i & b_i) | (~(a_i ^ b_i) & bor);
    end

    // Operand shifters, running borrow, bit counter and partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            bor  <= 1'b0;
            cnt  <= '0;
            sr   <= '0;
        end else if (load) begin
            a_sh <= bus.A;
            b_sh <= bus.B;
            bor  <= bus.Bin;
            cnt  <= '0;
        end else if (step) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            bor  <= bor_nx;
            cnt  <= cnt + 1'b1;
            sr   <= {d_i, sr[WIDTH-1:1]};
        end
    end

    // Visible result only changes on the edge that finishes the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q    <= '0;
            bout_q <= 1'b0;
        end else if (step && last) begin
            d_q    <= {d_i, sr[WIDTH-1:1]};
            bout_q <= bor_nx;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_q;

    // Operand sign bits, kept because the shifters lose them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (load) begin
            a_msb <= bus.A[WIDTH-1];
            b_msb <= bus.B[WIDTH-1];
        end
    end

    // Overflow: signs differ and the result sign departs from A's.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (step && last) begin
            ovf_q <= (a_msb ^ b_msb) & (d_i ^ a_msb);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.D    = d_q;
    assign bus.Bout = bout_q;
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_full_subtractor_serial8.sv
// tb_full_subtractor_serial8: directed vector table, handshake corner
// sequences and an operand sweep against an arithmetic reference.
module tb_full_subtractor_serial8;
    logic clk;
    logic rst;

    full_subtractor_serial8_if #(.WIDTH(8)) bus ();

    full_subtractor_serial8 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t       tv [10];
    int         n_chk;
    int         n_fail;
    logic [7:0] held_d;
    logic       held_b;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic bin, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.Bin   = ~bin;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (lat == 4) begin
                chk("hold_d", 32'(bus.D), 32'(held_d));
                chk("hold_bout", 32'(bus.Bout), 32'(held_b));
                chk("busy_mid", 32'(bus.busy), 32'd1);
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_chk(input string nm, input logic [7:0] a,
                           input logic [7:0] b, input logic bin,
                           input logic [7:0] ed, input logic eb,
                           input logic eo);
        int lat;
        do_op(a, b, bin, lat);
        chk({nm, "_lat"}, 32'(lat), 32'd9);
        chk({nm, "_d"}, 32'(bus.D), 32'(ed));
        chk({nm, "_bout"}, 32'(bus.Bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk({nm, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected x");
`endif
        held_d = ed;
        held_b = eb;
        @(negedge clk);
        chk({nm, "_done_pulse"}, 32'(bus.done), 32'd0);
        chk({nm, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_idle_hold"}, 32'(bus.D), 32'(ed));
    endtask

    initial begin
        int         n;
        logic       saw;
        logic [8:0] r;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic       ro;

        n_chk     = 0;
        n_fail    = 0;
        held_d    = 8'h00;
        held_b    = 1'b0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = 8'h00;
        bus.B     = 8'h00;
        bus.Bin   = 1'b0;

        tv[0] = '{8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0};
        tv[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        tv[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
        tv[3] = '{8'h0F, 8'h0F, 1'b1, 8'hFF, 1'b1, 1'b0};
        tv[4] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        tv[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        tv[6] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        tv[7] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[8] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
        tv[9] = '{8'hAA, 8'h55, 1'b1, 8'h54, 1'b0, 1'b1};

        #2;
        chk("rst_d", 32'(bus.D), 32'h00);
        chk("rst_bout", 32'(bus.Bout), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_chk($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].bin,
                    tv[i].d, tv[i].bout, tv[i].ovf);
        end

        // start pulsed mid-SHIFT with different operands is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = 8'h35;
        bus.B     = 8'h12;
        bus.Bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 8'hFF;
        bus.B     = 8'h00;
        bus.Bin   = 1'b1;
        n = 1;
        while (bus.done !== 1'b1 && n < 20) begin
            bus.start = (n == 4);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        chk("ign_lat", 32'(n), 32'd9);
        chk("ign_d", 32'(bus.D), 32'h23);
        chk("ign_bout", 32'(bus.Bout), 32'd0);
        held_d = 8'h23;
        held_b = 1'b0;
        @(negedge clk);
        chk("ign_idle_busy", 32'(bus.busy), 32'd0);

        // start held high: back-to-back operations every 9 cycles
        bus.start = 1'b1;
        bus.A     = 8'h10;
        bus.B     = 8'h0F;
        bus.Bin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.A     = 8'h00;
        bus.B     = 8'h01;
        bus.Bin   = 1'b0;
        wait_done(n);
        chk("b2b_lat1", 32'(n), 32'd9);
        chk("b2b_d1", 32'(bus.D), 32'h00);
        chk("b2b_bout1", 32'(bus.Bout), 32'd0);
        @(negedge clk);
        chk("b2b_busy2", 32'(bus.busy), 32'd1);
        wait_done(n);
        bus.start = 1'b0;
        chk("b2b_lat2", 32'(n), 32'd9);
        chk("b2b_d2", 32'(bus.D), 32'hFF);
        chk("b2b_bout2", 32'(bus.Bout), 32'd1);
        held_d = 8'hFF;
        held_b = 1'b1;
        @(negedge clk);
        chk("b2b_idle", 32'(bus.busy), 32'd0);

        // reset in the middle of SHIFT aborts without a done pulse
        bus.start = 1'b1;
        bus.A     = 8'h35;
        bus.B     = 8'h12;
        bus.Bin   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_d", 32'(bus.D), 32'h00);
        chk("abort_bout", 32'(bus.Bout), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw = 1'b1;
        end
        chk("abort_no_done", 32'(saw), 32'd0);
        held_d = 8'h00;
        held_b = 1'b0;
        run_chk("post_rst", 8'h9C, 8'h3A, 1'b1, 8'h61, 1'b0, 1'b1);

        // operand sweep against plain 9-bit arithmetic
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            r    = {1'b0, ra} - {1'b0, rb} - {8'h00, rbin};
            ro   = (ra[7] ^ rb[7]) & (r[7] ^ ra[7]);
            run_chk("rnd", ra, rb, rbin, r[7:0], r[8], ro);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
